// File: rtl/tx_packet_queue_pkg.sv
// Shared definitions for the TX packet queue: field widths, type bit, gap defaults, FSM states.
package tx_packet_queue_pkg;

  localparam int META_W               = 8;
  localparam int PREFIX_W             = 64;
  localparam int DATA_W               = 256;
  localparam int ENTRY_W              = META_W + PREFIX_W + DATA_W;
  localparam int META_TYPE_BIT        = 6;
  localparam int INTEREST_GAP_DEFAULT = 74;
  localparam int DATA_GAP_DEFAULT     = 330;
  localparam int GAP_CNT_W            = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  typedef struct packed {
    logic [META_W-1:0]   meta;
    logic [PREFIX_W-1:0] prefix;
    logic [DATA_W-1:0]   data;
  } packet_t;

  // Interest packets carry a 1 in the type bit of the meta byte.
  function automatic logic is_interest(input logic [META_W-1:0] meta);
    return meta[META_TYPE_BIT];
  endfunction

endpackage

// File: rtl/tx_packet_queue_if.sv
// Producer-side and serializer-side signals of the TX packet queue.
interface tx_packet_queue_if
  import tx_packet_queue_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                enq_valid;
  logic                enq_ready;
  logic [META_W-1:0]   enq_meta_data;
  logic [PREFIX_W-1:0] enq_prefix;
  logic [DATA_W-1:0]   enq_data;

  logic                TX_valid;
  logic [META_W-1:0]   packet_meta_data_input;
  logic [PREFIX_W-1:0] packet_prefix_input;
  logic [DATA_W-1:0]   packet_data_input;
  logic [OCC_W-1:0]    occupancy;
  logic                busy;

  modport master (
    output enq_valid, enq_meta_data, enq_prefix, enq_data,
    input  enq_ready, TX_valid, packet_meta_data_input, packet_prefix_input,
           packet_data_input, occupancy, busy
  );

  modport slave (
    input  enq_valid, enq_meta_data, enq_prefix, enq_data,
    output enq_ready, TX_valid, packet_meta_data_input, packet_prefix_input,
           packet_data_input, occupancy, busy
  );

endinterface

// File: rtl/packet_fifo.sv
// Plain FIFO of packet entries; knows nothing about transmit spacing.
module packet_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 328
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // A push offered while full is refused even if a pop happens in the same cycle.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and count updates; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the queue by clearing pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; stale contents are unreachable once the count is zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tx_packet_queue.sv
// Queues packets and hands them to the SPI serializer with type-dependent minimum spacing.
module tx_packet_queue
  import tx_packet_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int INTEREST_GAP = INTEREST_GAP_DEFAULT,
  parameter int DATA_GAP     = DATA_GAP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  tx_packet_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t                 state_q, state_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   tx_valid_q, tx_valid_d;
  packet_t                packet_q, packet_d;
  packet_t                enq_packet, head_packet;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]       fifo_count;

  assign enq_packet = {bus.enq_meta_data, bus.enq_prefix, bus.enq_data};
  assign fifo_pop   = (state_q == ST_ISSUE);

  packet_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.enq_valid),
    .push_data (enq_packet),
    .pop       (fifo_pop),
    .head_data (head_packet),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pop FSM: present the head for one cycle, then hold off for the gap of its type.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    packet_d  = packet_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        gap_cnt_d = is_interest(packet_q.meta) ? GAP_CNT_W'(INTEREST_GAP - 1)
                                               : GAP_CNT_W'(DATA_GAP - 1);
        state_d   = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // The count hits zero on the same edge we leave, so pulses land exactly GAP apart.
        if (gap_cnt_q > GAP_CNT_W'(1)) begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end else begin
          gap_cnt_d = '0;
          state_d   = fifo_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ISSUE) packet_d = head_packet;
    tx_valid_d = (state_d == ST_ISSUE);
  end

  // FSM, gap counter and registered packet outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      packet_q   <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_valid_q <= tx_valid_d;
      packet_q   <= packet_d;
    end
  end

  assign bus.enq_ready              = !fifo_full;
  assign bus.occupancy              = fifo_count;
  assign bus.busy                   = (state_q == ST_HOLDOFF) || !fifo_empty;
  assign bus.TX_valid               = tx_valid_q;
  assign bus.packet_meta_data_input = packet_q.meta;
  assign bus.packet_prefix_input    = packet_q.prefix;
  assign bus.packet_data_input      = packet_q.data;

endmodule
